// File: rtl/acumulador_10bit_pkg.sv
// Shared constants and FSM encoding for the 10-bit batch accumulator.
package acumulador_pkg;

    localparam int LARGURA = 10;

    typedef enum logic {
        ACUM  = 1'b0,
        SAIDA = 1'b1
    } estado_t;

endpackage

// File: rtl/acumulador_10bit_if.sv
// Operand/result handshake bundle between a producer/consumer and the accumulator.
interface acumulador_10bit_if;
    import acumulador_pkg::*;

    logic               in_valid;
    logic [LARGURA-1:0] in_dado;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready;
    logic [LARGURA-1:0] out_soma;
    logic               out_ovf;

    modport slave (
        input  in_valid, in_dado, out_ready,
        output in_ready, out_valid, out_soma, out_ovf
    );

    modport master (
        output in_valid, in_dado, out_ready,
        input  in_ready, out_valid, out_soma, out_ovf
    );

endinterface

// File: rtl/acumulador_10bit_soma.sv
// Plain 10-bit ripple-carry adder; no carry-out port, callers derive it themselves.
module soma_10bit (
    input  logic [9:0] a,
    input  logic [9:0] b,
    input  logic       cin,
    output logic [9:0] s
);

    logic [9:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 10; i++) begin : g_bit
        assign s[i] = a[i] ^ b[i] ^ c[i];
    end

    for (genvar i = 0; i < 9; i++) begin : g_carry
        assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

endmodule

// File: rtl/acumulador_10bit.sv
// Sums N_OPERANDOS unsigned 10-bit operands per batch, presents sum mod 1024 plus a
// sticky carry flag, then waits for the consumer before starting the next batch.
//
//   state | meaning
//   ACUM  | collecting operands, in_ready=1, out_soma shows the running sum
//   SAIDA | batch result presented, out_valid=1, waiting for out_ready
module acumulador_10bit
    import acumulador_pkg::*;
#(
    parameter int N_OPERANDOS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                limpa,
    acumulador_10bit_if.slave   bus
);

    localparam logic [LARGURA-1:0] CNT_FIM = LARGURA'(N_OPERANDOS);

    estado_t            estado, estado_nxt;
    logic [LARGURA-1:0] acc, acc_nxt;
    logic [LARGURA-1:0] cnt, cnt_nxt;
    logic               ovf, ovf_nxt;
    logic [LARGURA-1:0] soma;
    logic [LARGURA-1:0] cnt_inc;
    logic               carry;

    soma_10bit u_soma (
        .a   (acc),
        .b   (bus.in_dado),
        .cin (1'b0),
        .s   (soma)
    );

    // A wrapped unsigned sum is smaller than either addend exactly when it carried out.
    assign carry   = (soma < acc);
    assign cnt_inc = cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= ACUM;
            acc    <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            estado <= estado_nxt;
            acc    <= acc_nxt;
            cnt    <= cnt_nxt;
            ovf    <= ovf_nxt;
        end
    end

    always_comb begin
        estado_nxt = estado;
        acc_nxt    = acc;
        cnt_nxt    = cnt;
        ovf_nxt    = ovf;
        if (limpa) begin
            estado_nxt = ACUM;
            acc_nxt    = '0;
            cnt_nxt    = '0;
            ovf_nxt    = 1'b0;
        end else begin
            case (estado)
                ACUM: begin
                    if (bus.in_valid) begin
                        acc_nxt = soma;
                        cnt_nxt = cnt_inc;
                        ovf_nxt = ovf | carry;
                        if (cnt_inc == CNT_FIM) begin
                            estado_nxt = SAIDA;
                        end
                    end
                end
                SAIDA: begin
                    if (bus.out_ready) begin
                        estado_nxt = ACUM;
                        acc_nxt    = '0;
                        cnt_nxt    = '0;
                        ovf_nxt    = 1'b0;
                    end
                end
                default: estado_nxt = ACUM;
            endcase
        end
    end

    assign bus.in_ready  = (estado == ACUM);
    assign bus.out_valid = (estado == SAIDA);
    assign bus.out_soma  = acc;
    assign bus.out_ovf   = ovf;

endmodule
